// File: rtl/hazard_scheduler.sv
// ============================================================================
// Module   : hazard_scheduler
// Purpose  : Pipeline hazard control (memory wait, branch flush, load-use stall).
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scheduler #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_hazard,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_waitCnt;
   logic [CNT_W-1:0] w_waitNext;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;
   logic             w_applyRules;

   // Inputs are masked while reset is held so the block presents plain RUN flow.
   logic w_loadUse, w_branch, w_memReq, w_memReady;
   assign w_loadUse  = load_use_hazard & rst_n;
   assign w_branch   = branch_taken    & rst_n;
   assign w_memReq   = dmem_req        & rst_n;
   assign w_memReady = dmem_ready      & rst_n;

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      pipe_hold    = 1'b0;
      halted       = 1'b0;
      w_applyRules = 1'b0;
      w_nextState  = r_state;
      w_waitNext   = r_waitCnt;

      case (r_state)
         RUN: begin
            if (w_memReq && !w_memReady) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               pipe_hold   = 1'b1;
               w_waitNext  = c_ONE;
               w_nextState = (c_ONE >= c_TIMEOUT) ? HALT : MEM_WAIT;
            end else begin
               w_applyRules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!w_memReady) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               pipe_hold   = 1'b1;
               w_waitNext  = r_waitCnt + c_ONE;
               if (w_waitNext >= c_TIMEOUT) begin
                  w_nextState = HALT;
               end
            end else begin
               w_applyRules = 1'b1;
               w_waitNext   = '0;
               w_nextState  = RUN;
            end
         end
         HALT: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            halted     = 1'b1;
         end
         default: begin
            w_nextState = RUN;
            w_waitNext  = '0;
         end
      endcase

      // Branch flush outranks the load-use stall: the dependent instruction is squashed anyway.
      if (w_applyRules) begin
         if (w_branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (w_loadUse) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_waitCnt  <= '0;
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_waitNext;
         if (!pc_write && (r_stallCnt != c_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + c_ONE;
         end
         if (ifid_flush && (r_flushCnt != c_CNT_MAX)) begin
            r_flushCnt <= r_flushCnt + c_ONE;
         end
      end
   end

   assign stall_cycles = r_stallCnt;
   assign flush_count  = r_flushCnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
// ============================================================================
// Module   : tb_hazard_scheduler
// Purpose  : Table, directed and randomized checks of hazard_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scheduler;

   logic clk;
   logic rst_n, lu, br, rq, rd;

   logic pcA, ifwA, flA, bbA, hdA, haA;
   logic pcB, ifwB, flB, bbB, hdB, haB;
   logic [15:0] stA, fcA;
   logic [3:0]  stB, fcB;

   wire [5:0] outA = {pcA, ifwA, flA, bbA, hdA, haA};
   wire [5:0] outB = {pcB, ifwB, flB, bbB, hdB, haB};

   int checks = 0;
   int errors = 0;

   hazard_scheduler #(.CNT_W(16), .MEM_TIMEOUT(4)) dutA (
      .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .branch_taken(br),
      .dmem_req(rq), .dmem_ready(rd), .pc_write(pcA), .ifid_write(ifwA),
      .ifid_flush(flA), .idex_bubble(bbA), .pipe_hold(hdA), .halted(haA),
      .stall_cycles(stA), .flush_count(fcA));

   hazard_scheduler #(.CNT_W(4), .MEM_TIMEOUT(2)) dutB (
      .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .branch_taken(br),
      .dmem_req(rq), .dmem_ready(rd), .pc_write(pcB), .ifid_write(ifwB),
      .ifid_flush(flB), .idex_bubble(bbB), .pipe_hold(hdB), .halted(haB),
      .stall_cycles(stB), .flush_count(fcB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a halted flag, number of consecutive wait cycles, plain integer counters.
   typedef struct {
      bit halt;
      int waits;
      int stall;
      int flush;
      int tmo;
      int cmax;
   } mdl_t;

   mdl_t m [2];

   // Output bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halted}
   function automatic logic [5:0] mOut(input mdl_t s, input logic l, b, q, r, n);
      bit waiting;
      if (!n)     return 6'b110000;
      if (s.halt) return 6'b000011;
      waiting = (s.waits > 0) ? !r : (q && !r);
      if (waiting) return 6'b000010;
      if (b)       return 6'b111100;
      if (l)       return 6'b000100;
      return 6'b110000;
   endfunction

   function automatic mdl_t mNext(input mdl_t s, input logic l, b, q, r, n);
      mdl_t t;
      logic [5:0] o;
      t = s;
      o = mOut(s, l, b, q, r, n);
      if (!n) begin
         t.halt = 0; t.waits = 0; t.stall = 0; t.flush = 0;
         return t;
      end
      if (!o[5] && t.stall < t.cmax) t.stall++;
      if (o[3] && t.flush < t.cmax) t.flush++;
      if (!s.halt) begin
         if (o == 6'b000010) begin
            t.waits++;
            if (t.waits >= t.tmo) t.halt = 1;
         end else begin
            t.waits = 0;
         end
      end
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic cl, cb, cq, cr, cn;

   // Drive between edges, apply async reset to the model at once, then compare to the model.
   task automatic drive(input logic l, b, q, r, n);
      @(negedge clk);
      lu = l; br = b; rq = q; rd = r; rst_n = n;
      cl = l; cb = b; cq = q; cr = r; cn = n;
      if (!n) begin
         m[0] = mNext(m[0], l, b, q, r, n);
         m[1] = mNext(m[1], l, b, q, r, n);
      end
      #1;
      chk("outA",   {26'd0, outA}, {26'd0, mOut(m[0], l, b, q, r, n)});
      chk("stallA", {16'd0, stA},  m[0].stall);
      chk("flushA", {16'd0, fcA},  m[0].flush);
      chk("outB",   {26'd0, outB}, {26'd0, mOut(m[1], l, b, q, r, n)});
      chk("stallB", {28'd0, stB},  m[1].stall);
      chk("flushB", {28'd0, fcB},  m[1].flush);
   endtask

   task automatic tick();
      @(posedge clk);
      m[0] = mNext(m[0], cl, cb, cq, cr, cn);
      m[1] = mNext(m[1], cl, cb, cq, cr, cn);
   endtask

   typedef struct {
      logic l, b, q, r, n;
      logic [5:0] out;
      int stall;
      int flush;
   } vec_t;

   vec_t tbl [12];

   initial begin
      rst_n = 1'b0; lu = 0; br = 0; rq = 0; rd = 0;
      cl = 0; cb = 0; cq = 0; cr = 0; cn = 0;
      m[0] = '{halt: 0, waits: 0, stall: 0, flush: 0, tmo: 4, cmax: 65535};
      m[1] = '{halt: 0, waits: 0, stall: 0, flush: 0, tmo: 2, cmax: 15};

      // Sequence from reset on dutA; expected outputs are that cycle's, counters are pre-edge.
      tbl[0]  = '{1, 1, 1, 1, 0, 6'b110000, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 1, 6'b000100, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 1, 6'b110000, 1, 0};
      tbl[3]  = '{1, 1, 0, 0, 1, 6'b111100, 1, 0};
      tbl[4]  = '{0, 0, 0, 0, 1, 6'b110000, 1, 1};
      tbl[5]  = '{0, 0, 1, 0, 1, 6'b000010, 1, 1};
      tbl[6]  = '{0, 0, 1, 0, 1, 6'b000010, 2, 1};
      tbl[7]  = '{0, 1, 0, 0, 1, 6'b000010, 3, 1};
      tbl[8]  = '{0, 1, 0, 1, 1, 6'b111100, 4, 1};
      tbl[9]  = '{0, 0, 0, 0, 1, 6'b110000, 4, 2};
      tbl[10] = '{1, 0, 1, 1, 1, 6'b000100, 4, 2};
      tbl[11] = '{0, 0, 0, 0, 1, 6'b110000, 5, 2};

      drive(0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].l, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].n);
         chk($sformatf("tbl%0d_out", i), {26'd0, outA}, {26'd0, tbl[i].out});
         chk($sformatf("tbl%0d_stall", i), {16'd0, stA}, tbl[i].stall);
         chk($sformatf("tbl%0d_flush", i), {16'd0, fcA}, tbl[i].flush);
         tick();
      end

      // Three memory wait cycles then ready.
      drive(0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 1);
         chk("memwait_hold", {31'd0, hdA}, 32'd1);
         tick();
      end
      drive(0, 0, 1, 1, 1);
      chk("memready_hold", {31'd0, hdA}, 32'd0);
      tick();
      drive(0, 0, 0, 0, 1);
      chk("memwait_stall", {16'd0, stA}, 32'd3);
      chk("memwait_run", {26'd0, outA}, {26'd0, 6'b110000});
      tick();

      // Asynchronous reset between edges while waiting.
      drive(0, 0, 1, 0, 1); tick();
      drive(0, 0, 1, 0, 1); tick();
      drive(0, 0, 1, 0, 0);
      chk("arst_halted", {31'd0, haA}, 32'd0);
      chk("arst_hold",   {31'd0, hdA}, 32'd0);
      chk("arst_stall",  {16'd0, stA}, 32'd0);
      chk("arst_flush",  {16'd0, fcA}, 32'd0);
      tick();

      // Timeout to HALT, frozen outputs, reset recovery.
      drive(0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0, 1); tick();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
         chk("halt_frozen", {26'd0, outA}, {26'd0, 6'b000011});
         tick();
      end
      drive(0, 0, 0, 0, 1);
      chk("halt_stall", {16'd0, stA}, 32'd14);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("halt_rst_halted", {31'd0, haA}, 32'd0);
      chk("halt_rst_stall",  {16'd0, stA}, 32'd0);
      tick();
      drive(0, 0, 0, 0, 1);
      chk("halt_rst_run", {26'd0, outA}, {26'd0, 6'b110000});
      tick();

      // Stall counter saturation on the narrow instance.
      drive(0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 0, 1); tick();
      end
      drive(0, 0, 0, 0, 1);
      chk("sat_stallB", {28'd0, stB}, 32'd15);
      chk("sat_stallA", {16'd0, stA}, 32'd20);
      tick();

      // Randomized stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) != 0));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of performance counters.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 255, max consecutive data-memory wait cycles before halt (1..2^CNT_W-1).
REQ-003 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide load_use_hazard  input  1  load in EX feeds rs1/rs2 of instruction in ID.
REQ-006 SHALL provide branch_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-007 SHALL provide dmem_req  input  1  instruction in MEM accesses data memory this cycle.
REQ-008 SHALL provide dmem_ready  input  1  data memory completes access this cycle.
REQ-009 SHALL provide pc_write  output  1  PC register enable.
REQ-010 SHALL provide ifid_write  output  1  IF/ID register enable.
REQ-011 SHALL provide ifid_flush  output  1  IF/ID register loaded with NOP.
REQ-012 SHALL provide idex_bubble  output  1  ID/EX control fields zeroed (NOP).
REQ-013 SHALL provide pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB registers.
REQ-014 SHALL provide halted  output  1  scheduler in HALT state.
REQ-015 SHALL provide stall_cycles  output  CNT_W  count of cycles with pc_write=0.
REQ-016 SHALL provide flush_count  output  CNT_W  count of branch flushes issued.

Function
REQ-017 SHALL implement registered FSM states RUN, MEM_WAIT, HALT; outputs combinational from state and current inputs (zero-cycle control response).
REQ-018 SHALL, in RUN, evaluate in priority order: memory wait > branch flush > load-use stall > normal.
REQ-019 SHALL, in RUN with dmem_req=1 and dmem_ready=0: pipe_hold=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0; next state MEM_WAIT, wait counter loaded with 1.
REQ-020 SHALL, in RUN with branch_taken=1 (no memory wait): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, pipe_hold=0; flush_count increments.
REQ-021 SHALL, in RUN with load_use_hazard=1 (no wait, no branch): pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_hold=0.
REQ-022 SHALL, in RUN otherwise: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-023 SHALL, in MEM_WAIT with dmem_ready=0: same outputs as REQ-019; wait counter increments; when counter reaches MEM_TIMEOUT, next state HALT.
REQ-024 SHALL, in MEM_WAIT with dmem_ready=1: apply REQ-020..022 rules (memory condition ignored) in that cycle and return to RUN; counter cleared.
REQ-025 SHALL, in HALT: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0, halted=1; exit only via reset; all inputs ignored.
REQ-026 SHALL increment stall_cycles every cycle pc_write=0, including HALT.
REQ-027 SHALL saturate both counters at 2^CNT_W-1 (no wrap).
REQ-028 SHALL increment flush_count at most once per cycle; a branch during memory wait is not counted until REQ-024 cycle.

Reset
REQ-029 SHALL on rst_n=0 immediately force state RUN, wait counter 0, stall_cycles 0, flush_count 0, halted 0, regardless of clock.
REQ-030 SHALL, during reset, drive pc_write=1, ifid_write=1, others 0 (RUN outputs with inputs masked).
REQ-031 SHALL, on reset asserted mid-MEM_WAIT or HALT, abandon wait without further counter update.

Verification
REQ-032 SHALL cover: load_use_hazard=1 one cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1 after edge.
REQ-033 SHALL cover: branch_taken=1 and load_use_hazard=1 same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1, stall_cycles=0.
REQ-034 SHALL cover: dmem_req=1, dmem_ready=0 for 3 cycles then ready=1 -> pipe_hold=1 for 3 cycles, 0 on ready cycle; state RUN after; stall_cycles=3.
REQ-035 SHALL cover: MEM_TIMEOUT=4, dmem_ready held 0 -> halted=1 after 4th wait edge; outputs frozen for 10 further cycles; rst_n pulse -> RUN, counters 0.
REQ-036 SHALL cover: CNT_W=4, 20 consecutive load-use stalls -> stall_cycles saturates at 15.
REQ-037 SHALL cover: rst_n asserted asynchronously mid-MEM_WAIT between edges -> halted=0, pipe_hold=0, counters 0 before next clock edge.
